// File: rtl/tmr_scrub_scheduler.sv
// Round-robin scrub scheduler for a TMR instance array: sticky pending flags, req/ack to a shared scrub engine.
// Optional TMR_SCRUB_MASK_EN adds mask_i, which keeps masked instances out of the grant scan.
module tmr_scrub_scheduler #(
    parameter int unsigned N       = 10,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     err_i,
    input  logic             scrub_ack_i,
`ifdef TMR_SCRUB_MASK_EN
    input  logic [N-1:0]     mask_i,
`endif
    output logic             scrub_req_o,
    output logic [IDX_W-1:0] scrub_sel_o,
    output logic [N-1:0]     pending_o,
    output logic             err_any_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stateT;

    stateT             state, stateNxt;
    logic [IDX_W-1:0]  ptr, ptrNxt;
    logic [IDX_W-1:0]  sel, selNxt;
    logic [WAIT_W-1:0] waitCnt, waitNxt;
    logic [N-1:0]      pending, pendingNxt;
    logic [N-1:0]      clearMask;
    logic [CNT_W-1:0]  errCnt, errCntNxt;
    logic              timeoutFlag, timeoutNxt;

    logic [N-1:0]      eligible;
    logic [N-1:0]      rotated;
    logic              found;
    logic [IDX_W-1:0]  offs;
    logic [IDX_W:0]    pickSum;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  nextPtr;

`ifdef TMR_SCRUB_MASK_EN
    assign eligible = pending & ~mask_i;
`else
    assign eligible = pending;
`endif

    // Rotate so bit 0 is the instance at ptr, then take the first set bit.
    always_comb begin
        rotated = N'({eligible, eligible} >> ptr);
        found   = 1'b0;
        offs    = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rotated[j]) begin
                found = 1'b1;
                offs  = IDX_W'(j);
            end
        end
        pickSum = {1'b0, ptr} + {1'b0, offs};
        if (pickSum >= (IDX_W+1)'(N)) begin
            pickSum = pickSum - (IDX_W+1)'(N);
        end
        pick = IDX_W'(pickSum);
    end

    assign nextPtr = (sel == IDX_W'(N-1)) ? '0 : sel + IDX_W'(1);

    // Next-state and datapath updates; an error arriving with the ack keeps the bit set.
    always_comb begin
        stateNxt   = state;
        ptrNxt     = ptr;
        selNxt     = sel;
        waitNxt    = waitCnt;
        clearMask  = '0;
        errCntNxt  = errCnt;
        timeoutNxt = timeoutFlag;
        case (state)
            IDLE: begin
                if (found) begin
                    selNxt   = pick;
                    waitNxt  = '0;
                    stateNxt = REQ;
                end
            end
            REQ: begin
                if (scrub_ack_i) begin
                    clearMask = N'(1) << sel;
                    if (errCnt != {CNT_W{1'b1}}) begin
                        errCntNxt = errCnt + CNT_W'(1);
                    end
                    ptrNxt   = nextPtr;
                    stateNxt = IDLE;
                end else if (waitCnt == WAIT_W'(TIMEOUT-1)) begin
                    timeoutNxt = 1'b1;
                    ptrNxt     = nextPtr;
                    stateNxt   = IDLE;
                end else begin
                    waitNxt = waitCnt + WAIT_W'(1);
                end
            end
            default: stateNxt = IDLE;
        endcase
        pendingNxt = (pending & ~clearMask) | err_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            sel         <= '0;
            waitCnt     <= '0;
            pending     <= '0;
            errCnt      <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            state       <= stateNxt;
            ptr         <= ptrNxt;
            sel         <= selNxt;
            waitCnt     <= waitNxt;
            pending     <= pendingNxt;
            errCnt      <= errCntNxt;
            timeoutFlag <= timeoutNxt;
        end
    end

    assign scrub_req_o = (state == REQ);
    assign scrub_sel_o = sel;
    assign pending_o   = pending;
    assign err_any_o   = |pending;
    assign err_cnt_o   = errCnt;
    assign timeout_o   = timeoutFlag;

endmodule
